// File: rtl/serial_alu.sv
// Digit-serial add/subtract unit for the EXEC phase: one DIGIT_W slice per clock.
// Latency: NDIG+1 rising edges from the first edge that sees alu_start to alu_done high.
// Backpressure: level handshake; the unit holds DONE while alu_start stays high and returns to IDLE when it drops.
module serial_alu #(
    parameter int WIDTH   = 16,
    parameter int DIGIT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_start,
    input  logic             alu_op,
    input  logic             immediate,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [WIDTH-1:0] sgnext_imm,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_done,
    output logic             busy,
    output logic             carry,
    output logic             zero,
    output logic             overflow
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]               state;
    logic [WIDTH-1:0]         a_sr;
    logic [WIDTH-1:0]         b_sr;
    logic [WIDTH-1:0]         res_sr;
    logic                     c_reg;
    logic [IDX_W-1:0]         idx;

    logic [WIDTH-1:0]         b_sel;
    logic [DIGIT_W:0]         dsum;
    logic [WIDTH+DIGIT_W-1:0] res_cat;
    logic [WIDTH-1:0]         res_next;
    logic                     ovf_next;

    // Operand B mux; subtract is done as A + ~B + 1, so B is inverted here and the +1 rides in on the carry.
    always_comb begin
        b_sel = immediate ? sgnext_imm : rs2_data;
        if (alu_op) begin
            b_sel = ~b_sel;
        end
    end

    // One digit of the ripple: low slices of A and B plus the stored carry; the sum digit enters the result from the top.
    always_comb begin
        dsum     = {1'b0, a_sr[DIGIT_W-1:0]} + {1'b0, b_sr[DIGIT_W-1:0]} + {{DIGIT_W{1'b0}}, c_reg};
        res_cat  = {dsum[DIGIT_W-1:0], res_sr};
        res_next = res_cat[WIDTH+DIGIT_W-1:DIGIT_W];
        // On the last digit the low slice of a_sr/b_sr holds the operand MSB digits.
        ovf_next = (a_sr[DIGIT_W-1] == b_sr[DIGIT_W-1]) && (dsum[DIGIT_W-1] != a_sr[DIGIT_W-1]);
    end

    // Control FSM plus datapath registers; results and flags only move on DONE entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            c_reg      <= 1'b0;
            idx        <= '0;
            alu_result <= '0;
            carry      <= 1'b0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (alu_start) begin
                        a_sr  <= rs1_data;
                        b_sr  <= b_sel;
                        c_reg <= alu_op;
                        idx   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sr   <= a_sr >> DIGIT_W;
                    b_sr   <= b_sr >> DIGIT_W;
                    res_sr <= res_next;
                    c_reg  <= dsum[DIGIT_W];
                    idx    <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        state      <= S_DONE;
                        alu_result <= res_next;
                        carry      <= dsum[DIGIT_W];
                        zero       <= (res_next == '0);
                        overflow   <= ovf_next;
                    end
                end
                S_DONE: begin
                    // No restart while the request level is still high.
                    if (!alu_start) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        alu_done = (state == S_DONE);
        busy     = (state == S_RUN);
    end

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: directed handshake/reset cases plus random operations.
// Expected values come from a plain-arithmetic reference of the add/subtract rules.
// Outputs are sampled 1 time unit after each rising edge.
module tb_serial_alu;

    logic        clk;
    logic        reset;
    logic        alu_start;
    logic        alu_op;
    logic        immediate;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic [15:0] sgnext_imm;
    logic [15:0] alu_result;
    logic        alu_done;
    logic        busy;
    logic        carry;
    logic        zero;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    serial_alu #(.WIDTH(16), .DIGIT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .immediate  (immediate),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .sgnext_imm (sgnext_imm),
        .alu_result (alu_result),
        .alu_done   (alu_done),
        .busy       (busy),
        .carry      (carry),
        .zero       (zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: {overflow, zero, carry, result} of A op B, modulo 2^16.
    function automatic logic [18:0] ref_model(input logic [15:0] a, input logic [15:0] b, input logic op);
        int unsigned ua;
        int unsigned ub;
        int unsigned total;
        logic [15:0] r;
        logic        c;
        logic        ov;
        int          sa;
        int          sb;
        int          sr;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        if (op) begin
            total = ua + (32'h10000 - ub);   // A - B as A + 2^16 - B; bit 16 set means no borrow
            sr    = sa - sb;
        end else begin
            total = ua + ub;
            sr    = sa + sb;
        end
        r  = total[15:0];
        c  = total[16];
        ov = (sr > 32767) || (sr < -32768);
        return {ov, (r == 16'h0), c, r};
    endfunction

    logic [18:0] last_exp;

    // Issue one operation with alu_start held; checks latency, busy length, result and flags.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] r2,
                          input logic [15:0] imm, input logic isel, input logic op);
        int edges;
        int busy_cnt;
        logic [15:0] b;
        rs1_data   = a;
        rs2_data   = r2;
        sgnext_imm = imm;
        immediate  = isel;
        alu_op     = op;
        alu_start  = 1'b1;
        b = isel ? imm : r2;
        last_exp = ref_model(a, b, op);
        edges    = 0;
        busy_cnt = 0;
        while (edges < 20) begin
            tick();
            edges++;
            if (edges == 1) begin
                // Scramble inputs after latching; they must be ignored.
                rs1_data   = 16'($urandom);
                rs2_data   = 16'($urandom);
                sgnext_imm = 16'($urandom);
                immediate  = ~isel;
                alu_op     = ~op;
            end
            if (busy) busy_cnt++;
            if (alu_done) break;
        end
        check({tag, "_lat"},  edges, 5);
        check({tag, "_busy"}, busy_cnt, 4);
        check({tag, "_res"},  alu_result, last_exp[15:0]);
        check({tag, "_c"},    carry,      last_exp[16]);
        check({tag, "_z"},    zero,       last_exp[17]);
        check({tag, "_ov"},   overflow,   last_exp[18]);
    endtask

    task automatic drop_start(input string tag);
        alu_start = 1'b0;
        tick();
        check({tag, "_done_fall"}, alu_done, 1'b0);
    endtask

    initial begin
        int done_cnt;
        logic [15:0] held;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] ri;
        alu_start  = 1'b0;
        alu_op     = 1'b0;
        immediate  = 1'b0;
        rs1_data   = '0;
        rs2_data   = '0;
        sgnext_imm = '0;
        reset      = 1'b1;
        #12;
        check("rst_res",  alu_result, 16'h0);
        check("rst_done", alu_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_flags", {carry, zero, overflow}, 3'b000);
        reset = 1'b0;
        tick();

        // Directed cases with hand-computed results.
        run_op("add", 16'h1234, 16'h0FED, 16'h0000, 1'b0, 1'b0);
        check("add_const", {overflow, zero, carry, alu_result}, {3'b000, 16'h2221});
        drop_start("add");

        run_op("subz", 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1);
        check("subz_const", {overflow, zero, carry, alu_result}, {3'b011, 16'h0000});
        drop_start("subz");

        run_op("imm", 16'h0010, 16'hAAAA, 16'hFFFE, 1'b1, 1'b0);
        check("imm_const", {overflow, zero, carry, alu_result}, {3'b001, 16'h000E});
        drop_start("imm");

        run_op("ovf_add", 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 1'b0);
        check("ovf_add_const", {overflow, zero, carry, alu_result}, {3'b100, 16'h8000});
        drop_start("ovf_add");

        run_op("ovf_sub", 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b1);
        check("ovf_sub_const", {overflow, zero, carry, alu_result}, {3'b101, 16'h7FFF});

        // Hold start past done: stay in DONE, result frozen, no relatch of new operands.
        held = alu_result;
        rs1_data = 16'h0003;
        rs2_data = 16'h0004;
        alu_op   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_done", alu_done, 1'b1);
            check("hold_res",  alu_result, held);
            check("hold_busy", busy, 1'b0);
        end
        drop_start("hold");
        run_op("b2b", 16'h0003, 16'h0004, 16'h0000, 1'b0, 1'b0);
        check("b2b_const", alu_result, 16'h0007);
        drop_start("b2b");

        // Drop start during RUN: the op completes and done pulses for one cycle.
        rs1_data  = 16'h4321;
        rs2_data  = 16'h1111;
        immediate = 1'b0;
        alu_op    = 1'b0;
        alu_start = 1'b1;
        tick();
        tick();
        alu_start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (alu_done) done_cnt++;
        end
        check("midrun_done_cnt", done_cnt, 1);
        check("midrun_res", alu_result, 16'h5432);

        // Reset after two RUN edges: outputs clear asynchronously.
        rs1_data  = 16'h0F0F;
        rs2_data  = 16'h0101;
        alu_start = 1'b1;
        tick();
        tick();
        tick();
        check("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_res",  alu_result, 16'h0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", alu_done, 1'b0);
        check("mid_rst_flags", {carry, zero, overflow}, 3'b000);
        alu_start = 1'b0;
        #2;
        reset = 1'b0;
        tick();
        run_op("post_rst", 16'h0100, 16'h0001, 16'h0000, 1'b0, 1'b1);
        check("post_rst_const", {carry, alu_result}, {1'b1, 16'h00FF});
        drop_start("post_rst");

        // Random operations against the reference.
        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            ri = 16'($urandom);
            if (n % 8 == 0) rb = ra;
            run_op("rand", ra, rb, ri, 1'($urandom), 1'($urandom));
            drop_start("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
